paddle_ctl: RTL and testbench
=============================

// Module: paddle_ctl
// PURPOSE
//  Upstream position source for the paddle draw stage. Turns left/right buttons into the
//  paddle's top-left x_pos/y_pos, updating once per frame on the rising edge of vsync_in.
//  Output is held stable for the whole frame, so the draw stage never sees a tear.
//  Clamps the paddle to the visible area. Optionally ramps speed while a button is held.
// PARAMETERS
//  SCREEN_W      800  visible width in pixels
//  PADDLE_W      200  paddle width offset; the draw stage covers x_pos..x_pos+PADDLE_W
//  Y_POS         560  constant paddle y, driven on y_pos
//  X_INIT        300  x_pos after reset
//  MAX_SPEED     8    max pixels per frame; 1..63
//  ACCEL_FRAMES  4    frames held per +1 speed step (PADDLE_ACCEL_EN only); >=1
// PORTS
//  pclk         in   1   pixel clock, the only clock
//  reset_n      in   1   synchronous, active-low reset
//  vsync_in     in   1   vsync from the timing chain, in the pclk domain
//  btn_left     in   1   asynchronous, active-high
//  btn_right    in   1   asynchronous, active-high
//  freeze       in   1   pause: position and state hold while high
//  x_pos        out  12  paddle left x, registered
//  y_pos        out  12  paddle top y, equals Y_POS
//  at_left      out  1   high when x_pos==0
//  at_right     out  1   high when x_pos==XMAX
// BEHAVIOUR
//  - Reset (reset_n==0 at a pclk edge): all outputs and state are set.
//      x_pos=X_INIT, y_pos=Y_POS, state=IDLE, speed=0, frame counter=0.
//      Synchronizers=0, vsync history=0, at_left/at_right from X_INIT.
//  - Width rule: XMAX = SCREEN_W-1-PADDLE_W (599 at defaults).
//      Arithmetic is 13-bit internally, so nothing wraps.
//  - Buttons: a 2-FF synchronizer per button; L/R are the synchronized values.
//  - Frame tick: tick = vsync_in & ~vsync_d, where vsync_d is vsync_in registered.
//      tick is high for one cycle. All state updates happen only on tick with freeze==0.
//      On tick with freeze==1 nothing changes, and the tick is not deferred.
//  - FSM: IDLE, MOVE_L, MOVE_R. Evaluated on each qualified tick from synchronized L/R.
//      IDLE:   L&~R -> MOVE_L; R&~L -> MOVE_R; else stay. speed=0.
//      MOVE_L: L&~R -> stay, move left by speed; otherwise -> IDLE, speed=0, no move.
//      MOVE_R: mirror of MOVE_L.
//      L&R together is treated as no press.
//      A direction reversal always passes through IDLE, costing one tick with no motion.
//  - Entering MOVE_x: speed=initial speed (see CONFIGURATION); the paddle moves on the
//      next tick.
//  - Left move: x_pos = (x_pos < speed) ? 0 : x_pos-speed.
//  - Right move: x_pos = (x_pos+speed > XMAX) ? XMAX : x_pos+speed.
//  - Latency: x_pos changes on the pclk edge after the tick cycle, i.e. 2 cycles after
//      vsync_in rises. at_left/at_right update in the same cycle as x_pos.
//  - Reset mid-frame or mid-move restores reset values at once; no partial update.
//  - reset_n has priority over tick and freeze.
// CONFIGURATION
//  PADDLE_ACCEL_EN defined:
//    - On entering MOVE_x, speed=1.
//    - Each tick spent in MOVE_x counts toward acceleration. After ACCEL_FRAMES such
//        ticks, speed increments by 1, saturating at MAX_SPEED, and the counter clears.
//    - Leaving MOVE_x clears speed and the counter.
//  PADDLE_ACCEL_EN undefined:
//    - speed=MAX_SPEED on entering MOVE_x and stays there.
//    - The frame counter is absent.
// TESTING
//  1 reset_n=0 for 3 clk -> x_pos=300, y_pos=560, at_left=0, at_right=0; hold L with no
//      vsync -> x_pos stays 300.
//  2 (accel off) hold R, 5 vsync rises -> x_pos 300 (enter), then 308, 316, 324, 332;
//      each change 2 clk after the vsync rise.
//  3 (accel off) X_INIT=5, hold L, 2 ticks -> x_pos 5 then 0, at_left=1; further ticks
//      keep 0.
//  4 R held until x_pos=596, then 1 tick -> x_pos=599, at_right=1, no overshoot.
//  5 L&R both held -> state IDLE, x_pos constant; L->R switch -> one tick with no motion,
//      then increasing x.
//  6 freeze=1 during 3 ticks with R held -> x_pos frozen; reset_n=0 mid-move -> x_pos=300
//      next clk.
//  7 (accel on) hold R, 10 ticks -> per-tick deltas 0,1,1,1,1,2,2,2,2,3.

Source files
------------

// File: rtl/paddle_ctl.sv
// paddle_ctl: per-frame paddle position source for the draw stage.
//   Buttons are synchronized, evaluated once per frame on the rising edge
//   of vsync_in, and the resulting x position is held for the whole frame.
//   The paddle is clamped to 0..XMAX (XMAX = SCREEN_W-1-PADDLE_W).
// Optional feature macro: PADDLE_ACCEL_EN (speed ramps while a button is held;
//   when undefined the paddle moves at MAX_SPEED and has no frame counter).
// Ports:
//   pclk       pixel clock, the only clock
//   reset_n    synchronous active-low reset
//   vsync_in   vsync in the pclk domain
//   btn_left   asynchronous left button, active-high
//   btn_right  asynchronous right button, active-high
//   freeze     pause: position and state hold while high
//   x_pos      paddle left x (registered)
//   y_pos      paddle top y, constant Y_POS (registered)
//   at_left    high when x_pos == 0
//   at_right   high when x_pos == XMAX
module paddle_ctl #(
    parameter int unsigned SCREEN_W     = 800,
    parameter int unsigned PADDLE_W     = 200,
    parameter int unsigned Y_POS        = 560,
    parameter int unsigned X_INIT       = 300,
    parameter int unsigned MAX_SPEED    = 8,
    parameter int unsigned ACCEL_FRAMES = 4
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        vsync_in,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        freeze,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        at_left,
    output logic        at_right
);

    localparam int unsigned XMAX    = SCREEN_W - 1 - PADDLE_W;
    localparam int unsigned SPEED_W = 6;

    // Reject configurations that would wrap the 13-bit arithmetic or stall motion.
    if (MAX_SPEED < 1 || MAX_SPEED > 63 || ACCEL_FRAMES < 1 ||
        PADDLE_W >= SCREEN_W || SCREEN_W > 4096 || X_INIT > XMAX ||
        Y_POS > 4095) begin : g_bad_params
        $error("paddle_ctl: parameter out of range");
    end

`ifdef PADDLE_ACCEL_EN
    localparam int unsigned CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [SPEED_W-1:0] SPEED_INIT = SPEED_W'(1);
`else
    localparam logic [SPEED_W-1:0] SPEED_INIT = SPEED_W'(MAX_SPEED);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_L = 2'd1,
        MOVE_R = 2'd2
    } state_t;

    state_t             state;
    logic [SPEED_W-1:0] speed;
    logic [1:0]         sync_l;
    logic [1:0]         sync_r;
    logic               vsync_d;
    logic               tick;
`ifdef PADDLE_ACCEL_EN
    logic [CNT_W-1:0]   frame_cnt;
`endif

    logic        go_l;
    logic        go_r;
    logic        qtick;
    logic        moving;
    logic [12:0] x_ext;
    logic [12:0] spd_ext;
    logic [12:0] sum_r;
    logic [11:0] x_left;
    logic [11:0] x_right;
    logic [11:0] x_move;

    // Pressing both buttons counts as no press.
    assign go_l   = sync_l[1] & ~sync_r[1];
    assign go_r   = sync_r[1] & ~sync_l[1];
    assign qtick  = tick & ~freeze;
    assign moving = ((state == MOVE_L) && go_l) || ((state == MOVE_R) && go_r);

    // Candidate next position, clamped at both screen edges.
    always_comb begin
        x_ext   = {1'b0, x_pos};
        spd_ext = 13'(speed);
        sum_r   = x_ext + spd_ext;
        x_left  = (x_ext < spd_ext) ? 12'd0 : 12'(x_ext - spd_ext);
        x_right = (sum_r > 13'(XMAX)) ? 12'(XMAX) : 12'(sum_r);
        x_move  = (state == MOVE_L) ? x_left : x_right;
    end

    // Synchronizers, registered frame tick, FSM and position update.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            x_pos     <= 12'(X_INIT);
            y_pos     <= 12'(Y_POS);
            at_left   <= (X_INIT == 0);
            at_right  <= (X_INIT == XMAX);
            state     <= IDLE;
            speed     <= '0;
            sync_l    <= '0;
            sync_r    <= '0;
            vsync_d   <= 1'b0;
            tick      <= 1'b0;
`ifdef PADDLE_ACCEL_EN
            frame_cnt <= '0;
`endif
        end else begin
            sync_l  <= {sync_l[0], btn_left};
            sync_r  <= {sync_r[0], btn_right};
            vsync_d <= vsync_in;
            tick    <= vsync_in & ~vsync_d;

            if (qtick) begin
                unique case (state)
                    IDLE: begin
                        if (go_l) begin
                            state <= MOVE_L;
                            speed <= SPEED_INIT;
                        end else if (go_r) begin
                            state <= MOVE_R;
                            speed <= SPEED_INIT;
                        end else begin
                            speed <= '0;
                        end
                    end
                    default: begin
                        if (!moving) begin
                            // Release or reversal: one motionless tick via IDLE.
                            state <= IDLE;
                            speed <= '0;
                        end
                    end
                endcase

                if (moving) begin
                    x_pos    <= x_move;
                    at_left  <= (x_move == 12'd0);
                    at_right <= (x_move == 12'(XMAX));
                end

`ifdef PADDLE_ACCEL_EN
                if (!moving) begin
                    frame_cnt <= '0;
                end else if (frame_cnt == CNT_W'(ACCEL_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    if (speed < SPEED_W'(MAX_SPEED)) begin
                        speed <= speed + SPEED_W'(1);
                    end
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_paddle_ctl.sv
// tb_paddle_ctl: randomized self-checking bench for paddle_ctl.
//   A frame-level reference model (signed position, direction, speed) tracks
//   the expected paddle after every vsync rise; outputs are sampled on negedge.
module tb_paddle_ctl;

    localparam int XMAX      = 599;
    localparam int X_INIT    = 300;
    localparam int Y_POS     = 560;
    localparam int MAX_SPEED = 8;
    localparam int ACCEL_FR  = 4;
`ifdef PADDLE_ACCEL_EN
    localparam int INIT_SPEED = 1;
`else
    localparam int INIT_SPEED = MAX_SPEED;
`endif

    logic        pclk = 1'b0;
    logic        reset_n;
    logic        vsync_in;
    logic        btn_left;
    logic        btn_right;
    logic        freeze;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        at_left;
    logic        at_right;

    int errors = 0;
    int checks = 0;

    // Reference model: dir is -1 (left), 0 (idle), +1 (right).
    int m_x, m_dir, m_speed, m_cnt;

    paddle_ctl dut (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .vsync_in  (vsync_in),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .freeze    (freeze),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .at_left   (at_left),
        .at_right  (at_right)
    );

    always #5 pclk = ~pclk;

    task automatic model_reset();
        m_x = X_INIT; m_dir = 0; m_speed = 0; m_cnt = 0;
    endtask

    task automatic model_tick();
        int press;
        press = (btn_left && !btn_right) ? -1 : (btn_right && !btn_left) ? 1 : 0;
        if (freeze) return;
        if (m_dir == 0) begin
            if (press != 0) begin
                m_dir = press; m_speed = INIT_SPEED; m_cnt = 0;
            end
        end else if (press == m_dir) begin
            m_x = m_x + m_dir * m_speed;
            if (m_x < 0) m_x = 0;
            if (m_x > XMAX) m_x = XMAX;
`ifdef PADDLE_ACCEL_EN
            m_cnt++;
            if (m_cnt == ACCEL_FR) begin
                m_cnt = 0;
                if (m_speed < MAX_SPEED) m_speed++;
            end
`endif
        end else begin
            m_dir = 0; m_speed = 0; m_cnt = 0;
        end
    endtask

    // Set buttons and give the synchronizers time to settle.
    task automatic set_btn(input logic l, input logic r);
        @(negedge pclk);
        btn_left = l; btn_right = r;
        repeat (3) @(negedge pclk);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        reset_n = 1'b0; vsync_in = 1'b0;
        repeat (3) @(negedge pclk);
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge pclk);
    endtask

    // One vsync rise; x_mid is x_pos one clock after the rise (must be unchanged).
    task automatic frame(output logic [11:0] x_mid);
        @(negedge pclk);
        vsync_in = 1'b1;
        @(negedge pclk);
        x_mid = x_pos;
        @(negedge pclk);
        vsync_in = 1'b0;
        model_tick();
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; vsync_in = 1'b0; btn_left = 1'b0; btn_right = 1'b0; freeze = 1'b0;
        repeat (3) @(negedge pclk);
        checks++;
        if (x_pos !== 12'd300 || y_pos !== 12'd560 || at_left !== 1'b0 || at_right !== 1'b0) begin
            errors++;
            $display("FAIL reset: x=%0d y=%0d al=%b ar=%b, expected x=300 y=560 al=0 ar=0",
                     x_pos, y_pos, at_left, at_right);
        end
        reset_n = 1'b1;
        model_reset();
        set_btn(1'b1, 1'b0);
        repeat (20) @(negedge pclk);
        checks++;
        if (x_pos !== 12'd300) begin
            errors++;
            $display("FAIL no_vsync_hold: x=%0d expected 300", x_pos);
        end
    endtask

    task automatic test_move_right();
        logic [11:0] mid;
        logic [11:0] prev;
        int exp_seq [5] = '{300, 308, 316, 324, 332};
        set_btn(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            prev = x_pos;
            frame(mid);
            checks++;
            if (mid !== prev) begin
                errors++;
                $display("FAIL latency[%0d]: x one clk after vsync=%0d expected %0d", i, mid, prev);
            end
            checks++;
            if (x_pos !== 12'(m_x)) begin
                errors++;
                $display("FAIL move_right[%0d]: x=%0d expected %0d", i, x_pos, m_x);
            end
`ifndef PADDLE_ACCEL_EN
            checks++;
            if (x_pos !== 12'(exp_seq[i])) begin
                errors++;
                $display("FAIL move_right_seq[%0d]: x=%0d expected %0d", i, x_pos, exp_seq[i]);
            end
`endif
        end
    endtask

    task automatic test_left_clamp();
        logic [11:0] mid;
        int extra = 0;
        set_btn(1'b1, 1'b0);
        for (int i = 0; i < 200 && extra < 3; i++) begin
            frame(mid);
            if (m_x == 0) extra++;
            checks++;
            if (x_pos !== 12'(m_x) || at_left !== (m_x == 0) || at_right !== 1'b0) begin
                errors++;
                $display("FAIL left_clamp[%0d]: x=%0d al=%b ar=%b expected x=%0d al=%b ar=0",
                         i, x_pos, at_left, at_right, m_x, m_x == 0);
            end
        end
        checks++;
        if (x_pos !== 12'd0 || at_left !== 1'b1) begin
            errors++;
            $display("FAIL left_edge: x=%0d al=%b expected x=0 al=1", x_pos, at_left);
        end
    endtask

    task automatic test_right_clamp();
        logic [11:0] mid;
        int extra = 0;
        set_btn(1'b0, 1'b1);
        for (int i = 0; i < 400 && extra < 2; i++) begin
            frame(mid);
            if (m_x == XMAX) extra++;
            checks++;
            if (x_pos !== 12'(m_x) || at_right !== (m_x == XMAX) || at_left !== (m_x == 0)) begin
                errors++;
                $display("FAIL right_clamp[%0d]: x=%0d al=%b ar=%b expected x=%0d",
                         i, x_pos, at_left, at_right, m_x);
            end
        end
        checks++;
        if (x_pos !== 12'd599 || at_right !== 1'b1) begin
            errors++;
            $display("FAIL right_edge: x=%0d ar=%b expected x=599 ar=1", x_pos, at_right);
        end
    endtask

    task automatic test_both_and_reverse();
        logic [11:0] mid;
        logic [11:0] held;
        do_reset();
        set_btn(1'b1, 1'b1);
        held = x_pos;
        for (int i = 0; i < 3; i++) begin
            frame(mid);
            checks++;
            if (x_pos !== held) begin
                errors++;
                $display("FAIL both_pressed[%0d]: x=%0d expected %0d", i, x_pos, held);
            end
        end
        set_btn(1'b1, 1'b0);
        frame(mid);
        frame(mid);
        frame(mid);
        set_btn(1'b0, 1'b1);
        held = x_pos;
        frame(mid);
        checks++;
        if (x_pos !== held) begin
            errors++;
            $display("FAIL reverse_idle_tick: x=%0d expected %0d", x_pos, held);
        end
        frame(mid);
        frame(mid);
        checks++;
        if (x_pos !== 12'(m_x) || !(x_pos > held)) begin
            errors++;
            $display("FAIL reverse_then_right: x=%0d expected %0d (> %0d)", x_pos, m_x, held);
        end
    endtask

    task automatic test_freeze_and_reset();
        logic [11:0] mid;
        logic [11:0] held;
        do_reset();
        set_btn(1'b0, 1'b1);
        frame(mid);
        frame(mid);
        @(negedge pclk);
        freeze = 1'b1;
        held = x_pos;
        for (int i = 0; i < 3; i++) begin
            frame(mid);
            checks++;
            if (x_pos !== held) begin
                errors++;
                $display("FAIL freeze[%0d]: x=%0d expected %0d", i, x_pos, held);
            end
        end
        @(negedge pclk);
        freeze = 1'b0;
        frame(mid);
        checks++;
        if (x_pos !== 12'(m_x)) begin
            errors++;
            $display("FAIL unfreeze: x=%0d expected %0d", x_pos, m_x);
        end
        // Reset coinciding with a vsync rise while moving.
        @(negedge pclk);
        vsync_in = 1'b1;
        reset_n  = 1'b0;
        @(negedge pclk);
        checks++;
        if (x_pos !== 12'd300 || at_left !== 1'b0 || at_right !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_move: x=%0d expected 300", x_pos);
        end
        vsync_in = 1'b0;
        @(negedge pclk);
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge pclk);
    endtask

    task automatic test_random();
        logic [11:0] mid;
        for (int i = 0; i < 60; i++) begin
            set_btn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            freeze = ($urandom_range(0, 7) == 0);
            frame(mid);
            checks++;
            if (x_pos !== 12'(m_x) || y_pos !== 12'(Y_POS) ||
                at_left !== (m_x == 0) || at_right !== (m_x == XMAX)) begin
                errors++;
                $display("FAIL random[%0d]: x=%0d al=%b ar=%b expected x=%0d al=%b ar=%b",
                         i, x_pos, at_left, at_right, m_x, m_x == 0, m_x == XMAX);
            end
        end
        freeze = 1'b0;
    endtask

`ifdef PADDLE_ACCEL_EN
    task automatic test_accel();
        logic [11:0] mid;
        logic [11:0] prev;
        int exp_d [10] = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
        do_reset();
        set_btn(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            prev = x_pos;
            frame(mid);
            checks++;
            if (int'(x_pos) - int'(prev) != exp_d[i]) begin
                errors++;
                $display("FAIL accel_delta[%0d]: delta=%0d expected %0d",
                         i, int'(x_pos) - int'(prev), exp_d[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_move_right();
        test_left_clamp();
        test_right_clamp();
        test_both_and_reverse();
        test_freeze_and_reset();
        test_random();
`ifdef PADDLE_ACCEL_EN
        test_accel();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
